// File: rtl/ccd_capture_roi.sv
// ccd_capture_roi: sensor capture front end with ROI window, frame decimation, single-shot and clean stop.
// Optional test-pattern generator on oDATA is built in when CCD_CAPTURE_ROI_TPG_EN is defined.
module ccd_capture_roi #(
    parameter int DATA_W       = 12,
    parameter int COLUMN_WIDTH = 1280,
    parameter int CNT_W        = 16,
    parameter int FRAME_W      = 32,
    parameter int SKIP_W       = 4
) (
    input  logic               iCLK,
    input  logic               iRST,
    input  logic [DATA_W-1:0]  iDATA,
    input  logic               iFVAL,
    input  logic               iLVAL,
    input  logic               iSTART,
    input  logic               iEND,
    input  logic               iSINGLE,
    input  logic [SKIP_W-1:0]  iSKIP,
    input  logic [CNT_W-1:0]   iWIN_X0,
    input  logic [CNT_W-1:0]   iWIN_X1,
    input  logic [CNT_W-1:0]   iWIN_Y0,
    input  logic [CNT_W-1:0]   iWIN_Y1,
`ifdef CCD_CAPTURE_ROI_TPG_EN
    input  logic               iTPG,
`endif
    output logic [DATA_W-1:0]  oDATA,
    output logic               oDVAL,
    output logic [CNT_W-1:0]   oX_Cont,
    output logic [CNT_W-1:0]   oY_Cont,
    output logic [FRAME_W-1:0] oFrame_Cont,
    output logic               oFrame_Done,
    output logic               oLine_Err,
    output logic               oBusy
);

    // state   | meaning
    // IDLE    | not capturing, waiting for iSTART
    // ARMED   | waiting for a fresh FVAL rise
    // CAPTURE | frame in progress, pixels forwarded
    // SKIP    | frame in progress, dropped by decimation
    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, SKIP} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] COL_CNT = CNT_W'(COLUMN_WIDTH);

    state_t              state, state_nxt;
    logic                fval_q, fval_prev, lval_q, lval_prev;
    logic [DATA_W-1:0]   data_q;
    logic                fval_rise, fval_fall, lval_fall;
    logic [CNT_W-1:0]    x_cnt, y_cnt;
    logic [CNT_W-1:0]    win_x0, win_x1, win_y0, win_y1;
    logic [SKIP_W-1:0]   skip_cnt;
    logic                stop_pending, stop_now;
    logic                counting, cap_start, skip_start, done_set, err_clr, stop_set, dval;
    logic                in_win;
    logic [DATA_W-1:0]   pix;

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            fval_q    <= 1'b0;
            fval_prev <= 1'b0;
            lval_q    <= 1'b0;
            lval_prev <= 1'b0;
            data_q    <= '0;
        end else begin
            fval_q    <= iFVAL;
            fval_prev <= fval_q;
            lval_q    <= iLVAL;
            lval_prev <= lval_q;
            data_q    <= iDATA;
        end
    end

    assign fval_rise = fval_q & ~fval_prev;
    assign fval_fall = ~fval_q & fval_prev;
    assign lval_fall = ~lval_q & lval_prev;
    assign stop_now  = stop_pending | iEND;

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (iSTART && !iEND) state_nxt = ARMED;
            ARMED:   if (iEND)            state_nxt = IDLE;
                     else if (fval_rise)  state_nxt = (skip_cnt == '0) ? CAPTURE : SKIP;
            CAPTURE: if (fval_fall)       state_nxt = (iSINGLE || stop_now) ? IDLE : ARMED;
            SKIP:    if (fval_fall)       state_nxt = stop_now ? IDLE : ARMED;
            default:                      state_nxt = IDLE;
        endcase
    end

    always_comb begin
        oBusy      = (state != IDLE);
        counting   = (state == CAPTURE) || (state == SKIP);
        cap_start  = (state == ARMED) && !iEND && fval_rise && (skip_cnt == '0);
        skip_start = (state == ARMED) && !iEND && fval_rise && (skip_cnt != '0);
        done_set   = (state == CAPTURE) && fval_fall;
        err_clr    = (state == IDLE) && iSTART && !iEND;
        stop_set   = counting && iEND;
        dval       = (state == CAPTURE) && lval_q && in_win;
    end

    // Decimation, frame count and window shadow only change at the start of a frame.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            skip_cnt    <= '0;
            oFrame_Cont <= '0;
            win_x0      <= '0;
            win_x1      <= '0;
            win_y0      <= '0;
            win_y1      <= '0;
        end else if (cap_start) begin
            skip_cnt    <= iSKIP;
            oFrame_Cont <= oFrame_Cont + 1'b1;
            win_x0      <= iWIN_X0;
            win_x1      <= iWIN_X1;
            win_y0      <= iWIN_Y0;
            win_y1      <= iWIN_Y1;
        end else if (skip_start) begin
            skip_cnt    <= skip_cnt - 1'b1;
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST)                     stop_pending <= 1'b0;
        else if (state_nxt == IDLE)   stop_pending <= 1'b0;
        else if (stop_set)            stop_pending <= 1'b1;
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (!counting || fval_rise) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (lval_fall) begin
            x_cnt <= '0;
            if (y_cnt != CNT_MAX) y_cnt <= y_cnt + 1'b1;
        end else if (lval_q && x_cnt != CNT_MAX) begin
            x_cnt <= x_cnt + 1'b1;
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST)                                       oLine_Err <= 1'b0;
        else if (err_clr)                               oLine_Err <= 1'b0;
        else if (counting && lval_fall && x_cnt != COL_CNT) oLine_Err <= 1'b1;
    end

    assign in_win = (x_cnt >= win_x0) && (x_cnt <= win_x1) &&
                    (y_cnt >= win_y0) && (y_cnt <= win_y1);

`ifdef CCD_CAPTURE_ROI_TPG_EN
    logic tpg_q;
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) tpg_q <= 1'b0;
        else      tpg_q <= iTPG;
    end
    assign pix = tpg_q ? (DATA_W'(x_cnt) + DATA_W'(y_cnt) + oFrame_Cont[DATA_W-1:0]) : data_q;
`else
    assign pix = data_q;
`endif

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            oDATA       <= '0;
            oDVAL       <= 1'b0;
            oX_Cont     <= '0;
            oY_Cont     <= '0;
            oFrame_Done <= 1'b0;
        end else begin
            oDATA       <= dval ? pix : '0;
            oDVAL       <= dval;
            oX_Cont     <= x_cnt;
            oY_Cont     <= y_cnt;
            oFrame_Done <= done_set;
        end
    end

endmodule

// File: tb/tb_ccd_capture_roi.sv
// Bench for ccd_capture_roi: frame-level reference model with randomized pixels, windows and gaps.
// Build with CCD_CAPTURE_ROI_TPG_EN defined to also exercise the test-pattern path.
module tb_ccd_capture_roi;
    localparam int DW = 12, CW = 16, FW = 32, SW = 4, COL = 8;

    logic          clk = 1'b0, rst = 1'b1;
    logic [DW-1:0] din = '0;
    logic          fval = 0, lval = 0, start = 0, stop_pin = 0, single = 0;
    logic [SW-1:0] skip = '0;
    logic [CW-1:0] wx0 = 0, wx1 = 7, wy0 = 0, wy1 = 3;
    logic [DW-1:0] o_data;
    logic          o_dval, o_done, o_err, o_busy;
    logic [CW-1:0] o_x, o_y;
    logic [FW-1:0] o_fcnt;
`ifdef CCD_CAPTURE_ROI_TPG_EN
    logic tpg = 1'b0;
`endif

    ccd_capture_roi #(.DATA_W(DW), .COLUMN_WIDTH(COL), .CNT_W(CW), .FRAME_W(FW), .SKIP_W(SW)) dut (
        .iCLK(clk), .iRST(rst), .iDATA(din), .iFVAL(fval), .iLVAL(lval),
        .iSTART(start), .iEND(stop_pin), .iSINGLE(single), .iSKIP(skip),
        .iWIN_X0(wx0), .iWIN_X1(wx1), .iWIN_Y0(wy0), .iWIN_Y1(wy1),
`ifdef CCD_CAPTURE_ROI_TPG_EN
        .iTPG(tpg),
`endif
        .oDATA(o_data), .oDVAL(o_dval), .oX_Cont(o_x), .oY_Cont(o_y),
        .oFrame_Cont(o_fcnt), .oFrame_Done(o_done), .oLine_Err(o_err), .oBusy(o_busy));

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0, cyc = 0;
    int dval_cnt = 0, done_cnt = 0, tpg_px = -1;
    always @(posedge clk) cyc <= cyc + 1;

    // Frame-level model: mode 0 idle, 1 armed, 2 inside a sensor frame (captured or dropped).
    int m_mode = 0, m_skip = 0, m_wx0, m_wx1, m_wy0, m_wy1;
    int unsigned m_fcnt = 0;
    bit m_capt = 0, m_stop = 0, m_err = 0, m_prev_f = 0;

    // Expected outputs, two cycles after the pins that produce them.
    bit          r_vld[8], r_dval[8], r_done[8];
    logic [DW-1:0] r_data[8];
    int          r_x[8], r_y[8];
    int unsigned r_fcnt[8];

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step(input bit f, input bit l, input int px, input int py, input bit st, input bit en);
        logic [DW-1:0] d;
        bit dv, dn;
        int k;
        d = DW'($urandom);
        fval = f; lval = l; din = d; start = st; stop_pin = en;
        dn = 0;
        if (en) begin
            if (m_mode == 2) m_stop = 1;
            else m_mode = 0;
        end else if (st && m_mode == 0) begin
            m_mode = 1;
            m_err = 0;
        end
        if (f && !m_prev_f && m_mode == 1) begin
            m_mode = 2;
            if (m_skip == 0) begin
                m_capt = 1; m_fcnt++; m_skip = int'(skip);
                m_wx0 = int'(wx0); m_wx1 = int'(wx1); m_wy0 = int'(wy0); m_wy1 = int'(wy1);
            end else begin
                m_capt = 0; m_skip--;
            end
        end
        if (!f && m_prev_f && m_mode == 2) begin
            dn = m_capt;
            if (m_stop || (m_capt && single)) begin m_mode = 0; m_stop = 0; end
            else m_mode = 1;
        end
        m_prev_f = f;
        dv = (m_mode == 2) && m_capt && l && px >= m_wx0 && px <= m_wx1 && py >= m_wy0 && py <= m_wy1;
        k = (cyc + 2) % 8;
        r_vld[k] = 1; r_dval[k] = dv; r_done[k] = dn; r_x[k] = px; r_y[k] = py; r_fcnt[k] = m_fcnt;
        r_data[k] = dv ? d : '0;
`ifdef CCD_CAPTURE_ROI_TPG_EN
        if (dv && tpg) r_data[k] = DW'(px + py + int'(m_fcnt));
`endif
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin : compare
        int k;
        k = cyc % 8;
        if (!rst && r_vld[k]) begin
            chk("dval", o_dval, r_dval[k]);
            chk("data", o_data, r_data[k]);
            if (r_dval[k]) begin
                chk("x_cont", o_x, r_x[k]);
                chk("y_cont", o_y, r_y[k]);
            end
            chk("frame_done", o_done, r_done[k]);
            chk("frame_cont", o_fcnt, r_fcnt[k]);
            if (o_dval) dval_cnt++;
            if (o_done) done_cnt++;
            if (o_dval && o_x == 3 && o_y == 2) tpg_px = int'(o_data);
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(fval, 0, 0, 0, 0, 0);
    endtask

    task automatic quiet_check(input string nm);
        chk({nm, "_busy"}, o_busy, m_mode != 0);
        chk({nm, "_line_err"}, o_err, m_err);
    endtask

    task automatic pulse(input bit st, input bit en);
        step(0, 0, 0, 0, st, en);
        idle(2);
    endtask

    // Four-line frame; short_line gets 7 pixels, end_line pulses iEND mid-line.
    task automatic drive_frame(input int short_line, input int end_line, output int got, output int dn);
        int c0, d0, len;
        c0 = dval_cnt; d0 = done_cnt;
        step(1, 0, 0, 0, 0, 0);
        for (int g = 0; g < int'($urandom_range(1, 3)); g++) step(1, 0, 0, 0, 0, 0);
        for (int ln = 0; ln < 4; ln++) begin
            len = (ln == short_line) ? COL - 1 : COL;
            for (int i = 0; i < len; i++) step(1, 1, i, ln, 0, ln == end_line && i == 3);
            if (m_mode == 2 && len != COL) m_err = 1;
            for (int g = 0; g < int'($urandom_range(1, 3)); g++) step(1, 0, 0, 0, 0, 0);
        end
        if (end_line >= 0) chk("busy_before_fall", o_busy, 1);
        step(0, 0, 0, 0, 0, 0);
        idle(2);
        got = dval_cnt - c0;
        dn = done_cnt - d0;
        quiet_check("frame_end");
    endtask

    int got, dn;
    int exp_sk[6] = '{32, 0, 0, 32, 0, 0};

    initial begin
        idle(3);
        chk("reset_busy", o_busy, 0);
        chk("reset_fcnt", o_fcnt, 0);
        chk("reset_dval", o_dval, 0);
        chk("reset_line_err", o_err, 0);
        rst = 0;
        idle(3);

        // Basic full-window capture of two frames
        pulse(1, 0);
        quiet_check("armed");
        for (int f = 0; f < 2; f++) begin
            drive_frame(-1, -1, got, dn);
            chk("basic_dval_count", got, 32);
            chk("basic_done_count", dn, 1);
        end
        chk("basic_fcnt", o_fcnt, 2);
        pulse(0, 1);
        quiet_check("basic_stop");

        // ROI window, then an empty window
        wx0 = 2; wx1 = 5; wy0 = 1; wy1 = 2;
        pulse(1, 0);
        drive_frame(-1, -1, got, dn);
        chk("roi_dval_count", got, 8);
        chk("roi_fcnt", o_fcnt, 3);
        wx0 = 6; wx1 = 3;
        drive_frame(-1, -1, got, dn);
        chk("empty_dval_count", got, 0);
        chk("empty_done_count", dn, 1);
        chk("empty_fcnt", o_fcnt, 4);
        pulse(0, 1);

        // Decimation: capture one, drop two
        wx0 = 0; wx1 = 7; wy0 = 0; wy1 = 3; skip = 2;
        pulse(1, 0);
        for (int f = 0; f < 6; f++) begin
            drive_frame(-1, -1, got, dn);
            chk("skip_dval_count", got, exp_sk[f]);
        end
        chk("skip_fcnt", o_fcnt, 6);
        pulse(0, 1);
        skip = 0;

        // Single shot
        single = 1;
        pulse(1, 0);
        drive_frame(-1, -1, got, dn);
        chk("single_dval_count", got, 32);
        chk("single_busy", o_busy, 0);
        drive_frame(-1, -1, got, dn);
        chk("single_no_second", got, 0);
        single = 0;

        // Stop requested mid-line completes the frame
        pulse(1, 0);
        drive_frame(-1, 1, got, dn);
        chk("stop_dval_count", got, 32);
        chk("stop_done_count", dn, 1);
        chk("stop_busy", o_busy, 0);
        drive_frame(-1, -1, got, dn);
        chk("stop_no_frame2", got, 0);
        chk("stop_fcnt", o_fcnt, 8);
        pulse(1, 1);
        chk("start_end_same_cycle_busy", o_busy, 0);

        // Short line sets a sticky error cleared by the next start
        pulse(1, 0);
        drive_frame(2, -1, got, dn);
        chk("line_err_set", o_err, 1);
        pulse(0, 1);
        chk("line_err_sticky", o_err, 1);
        pulse(1, 0);
        chk("line_err_cleared", o_err, 0);

        // Reset mid-frame
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 1, i, 0, 0, 0);
        rst = 1;
        #1;
        chk("rst_fcnt", o_fcnt, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_dval", o_dval, 0);
        chk("rst_data", o_data, 0);
        chk("rst_x", o_x, 0);
        chk("rst_y", o_y, 0);
        chk("rst_done", o_done, 0);
        chk("rst_line_err", o_err, 0);
        m_mode = 0; m_fcnt = 0; m_skip = 0; m_err = 0; m_stop = 0;
        for (int i = 5; i < 8; i++) step(1, 1, i, 0, 0, 0);
        rst = 0;
        for (int i = 0; i < 8; i++) step(1, 1, i, 1, 0, 0);
        step(1, 0, 0, 0, 0, 0); step(1, 0, 0, 0, 0, 0); step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0); step(1, 0, 0, 0, 0, 0);
        chk("rst_partial_no_dval", o_dval, 0);
        step(0, 0, 0, 0, 0, 0);
        idle(2);
        quiet_check("after_rst");
        chk("after_rst_fcnt", o_fcnt, 0);
        drive_frame(-1, -1, got, dn);
        chk("after_rst_dval_count", got, 32);
        chk("after_rst_fcnt_new", o_fcnt, 1);
        pulse(0, 1);

        // Randomized windows, decimation and gaps
        for (int r = 0; r < 6; r++) begin
            wx0 = CW'($urandom_range(0, 8)); wx1 = CW'($urandom_range(0, 8));
            wy0 = CW'($urandom_range(0, 4)); wy1 = CW'($urandom_range(0, 4));
            skip = SW'($urandom_range(0, 2));
            pulse(1, 0);
            for (int f = 0; f < 3; f++) drive_frame(-1, -1, got, dn);
            pulse(0, 1);
            quiet_check("random");
        end
        skip = 0;

`ifdef CCD_CAPTURE_ROI_TPG_EN
        rst = 1;
        idle(2);
        m_mode = 0; m_fcnt = 0; m_skip = 0; m_err = 0; m_stop = 0;
        rst = 0;
        wx0 = 0; wx1 = 7; wy0 = 0; wy1 = 3;
        tpg = 1;
        pulse(1, 0);
        drive_frame(-1, -1, got, dn);
        chk("tpg_pixel_3_2", tpg_px, 6);
        tpg = 0;
        pulse(0, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
